// File: rtl/clock_enable_bank.sv
// PLL lock supervisor: holds a synchronous system reset until lock has been stable for
// LOCK_DELAY cycles, then runs CHANNELS fractional NCO clock-enable generators.
module clock_enable_bank #(
  parameter int CHANNELS    = 4,
  parameter int ACC_WIDTH   = 16,
  parameter int LOCK_DELAY  = 1024,
  parameter int DEFAULT_INC = 0,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pll_locked,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_channel,
  input  logic [ACC_WIDTH-1:0] cfg_inc,
  input  logic [ACC_WIDTH-1:0] cfg_phase,
  input  logic                 resync,
  input  logic [CHANNELS-1:0]  ce_mask,
  output logic [CHANNELS-1:0]  ce_out,
  output logic                 ready,
  output logic                 sys_reset_n
);

  localparam int CNT_W = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(LOCK_DELAY - 1);
  localparam logic [ACC_WIDTH-1:0] INC_RST  = ACC_WIDTH'(DEFAULT_INC);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABILISE,
    RUN
  } state_t;

  state_t                              state_q, state_d;
  logic                                sync1_q, lock_s_q;
  logic [CNT_W-1:0]                    counter_q, counter_d;
  logic                                ready_q, ready_d;
  logic [CHANNELS-1:0]                 ce_out_q, ce_out_d;
  logic [CHANNELS-1:0][ACC_WIDTH-1:0]  inc_q, inc_d;
  logic [CHANNELS-1:0][ACC_WIDTH-1:0]  phase_q, phase_d;
  logic [CHANNELS-1:0][ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CHANNELS-1:0][ACC_WIDTH:0]    sum;
  logic                                load_phase, advance;

  // Lock supervision: loss of lock always wins over counter completion or resync.
  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    load_phase = 1'b0;
    advance    = 1'b0;
    unique case (state_q)
      WAIT_LOCK: begin
        counter_d = '0;
        if (lock_s_q) state_d = STABILISE;
      end
      STABILISE: begin
        counter_d = counter_q + 1'b1;
        if (!lock_s_q) begin
          state_d   = WAIT_LOCK;
          counter_d = '0;
        end else if (counter_q == CNT_LAST) begin
          state_d    = RUN;
          counter_d  = '0;
          load_phase = 1'b1;
        end
      end
      RUN: begin
        counter_d = '0;
        if (!lock_s_q)   state_d    = WAIT_LOCK;
        else if (resync) load_phase = 1'b1;
        else             advance    = 1'b1;
      end
      default: begin
        state_d   = WAIT_LOCK;
        counter_d = '0;
      end
    endcase
  end

  assign ready_d = (state_d == RUN);

  // NCO accumulators: the carry out of each add is the enable pulse.
  always_comb begin
    acc_d    = acc_q;
    ce_out_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
    end
    if (load_phase) begin
      acc_d = phase_q;
    end else if (advance) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_d[i]    = sum[i][ACC_WIDTH-1:0];
        ce_out_d[i] = sum[i][ACC_WIDTH] & ce_mask[i];
      end
    end
  end

  // An index with no matching channel simply writes nothing.
  always_comb begin
    inc_d   = inc_q;
    phase_d = phase_q;
    if (cfg_we) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_channel == CH_W'(i)) begin
          inc_d[i]   = cfg_inc;
          phase_d[i] = cfg_phase;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      lock_s_q  <= 1'b0;
      state_q   <= WAIT_LOCK;
      counter_q <= '0;
      ready_q   <= 1'b0;
      ce_out_q  <= '0;
      inc_q     <= {CHANNELS{INC_RST}};
      phase_q   <= '0;
      acc_q     <= '0;
    end else begin
      sync1_q   <= pll_locked;
      lock_s_q  <= sync1_q;
      state_q   <= state_d;
      counter_q <= counter_d;
      ready_q   <= ready_d;
      ce_out_q  <= ce_out_d;
      inc_q     <= inc_d;
      phase_q   <= phase_d;
      acc_q     <= acc_d;
    end
  end

  assign ce_out      = ce_out_q;
  assign ready       = ready_q;
  assign sys_reset_n = ready_q;

endmodule

// File: tb/tb_clock_enable_bank.sv
// Directed bench for clock_enable_bank: lock timing, NCO patterns, config hazards, lock loss.
module tb_clock_enable_bank;

  // Five channels so that cfg_channel is 3 bits wide and index 5 is out of range.
  localparam int CH = 5;
  localparam int AW = 8;
  localparam int LD = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pll_locked = 1'b0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_channel = '0;
  logic [AW-1:0] cfg_inc = '0;
  logic [AW-1:0] cfg_phase = '0;
  logic          resync = 1'b0;
  logic [CH-1:0] ce_mask = '0;
  logic [CH-1:0] ce_out;
  logic          ready;
  logic          sys_reset_n;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [CH-1:0] mask;
    logic          rs;
    logic [CH-1:0] exp;
  } vec_t;

  vec_t tbl [38];

  always #5 clk = ~clk;

  clock_enable_bank #(
    .CHANNELS   (CH),
    .ACC_WIDTH  (AW),
    .LOCK_DELAY (LD),
    .DEFAULT_INC(0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
    .cfg_we     (cfg_we),
    .cfg_channel(cfg_channel),
    .cfg_inc    (cfg_inc),
    .cfg_phase  (cfg_phase),
    .resync     (resync),
    .ce_mask    (ce_mask),
    .ce_out     (ce_out),
    .ready      (ready),
    .sys_reset_n(sys_reset_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic write_cfg(input logic [2:0] ch, input logic [AW-1:0] inc, input logic [AW-1:0] ph);
    cfg_we      = 1'b1;
    cfg_channel = ch;
    cfg_inc     = inc;
    cfg_phase   = ph;
    step();
    cfg_we      = 1'b0;
  endtask

  initial begin
    logic early;
    int   cnt0, cnt3, pulses;
    logic [CH-1:0] exp_oor [8];

    // RUN-edge patterns: ch0 inc64/ph0, ch1 inc96/ph0, ch2 inc64/ph192, ch3 and ch4 inc0.
    tbl = '{
      '{5'h1f, 1'b0, 5'h04}, '{5'h1f, 1'b0, 5'h00}, '{5'h1f, 1'b0, 5'h02}, '{5'h1f, 1'b0, 5'h01},
      '{5'h1f, 1'b0, 5'h04}, '{5'h1f, 1'b0, 5'h02}, '{5'h1f, 1'b0, 5'h00}, '{5'h1f, 1'b0, 5'h03},
      '{5'h1f, 1'b0, 5'h04}, '{5'h1f, 1'b0, 5'h00}, '{5'h1f, 1'b0, 5'h02}, '{5'h1f, 1'b0, 5'h01},
      '{5'h1f, 1'b0, 5'h04}, '{5'h1f, 1'b0, 5'h02}, '{5'h1f, 1'b0, 5'h00}, '{5'h1f, 1'b0, 5'h03},
      '{5'h1e, 1'b0, 5'h04}, '{5'h1e, 1'b0, 5'h00}, '{5'h1e, 1'b0, 5'h02}, '{5'h1e, 1'b0, 5'h00},
      '{5'h1e, 1'b0, 5'h04}, '{5'h1e, 1'b0, 5'h02}, '{5'h1e, 1'b0, 5'h00}, '{5'h1e, 1'b0, 5'h02},
      '{5'h1e, 1'b0, 5'h04}, '{5'h1e, 1'b0, 5'h00},
      '{5'h1f, 1'b0, 5'h02}, '{5'h1f, 1'b0, 5'h01}, '{5'h1f, 1'b0, 5'h04}, '{5'h1f, 1'b0, 5'h02},
      '{5'h1f, 1'b0, 5'h00}, '{5'h1f, 1'b0, 5'h03},
      '{5'h1f, 1'b1, 5'h00},
      '{5'h1f, 1'b0, 5'h04}, '{5'h1f, 1'b0, 5'h00}, '{5'h1f, 1'b0, 5'h02}, '{5'h1f, 1'b0, 5'h01},
      '{5'h1f, 1'b0, 5'h04}
    };
    exp_oor = '{5'h04, 5'h01, 5'h02, 5'h01, 5'h04, 5'h03, 5'h00, 5'h03};

    // Reset state
    step_n(2);
    check("rst_ready", ready, 1'b0);
    check("rst_sys_reset_n", sys_reset_n, 1'b0);
    check("rst_ce_out", ce_out, '0);
    reset = 1'b1;
    step();

    write_cfg(3'd0, 8'd64, 8'd0);
    write_cfg(3'd1, 8'd96, 8'd0);
    write_cfg(3'd2, 8'd64, 8'd192);
    write_cfg(3'd3, 8'd0,  8'h33);
    ce_mask = 5'h1f;

    // Lock timing: ready rises exactly after E0+LD+2
    pll_locked = 1'b1;
    early = 1'b0;
    for (int k = 0; k < LD + 2; k++) begin
      step();
      if (ready || sys_reset_n || (ce_out != '0)) early = 1'b1;
    end
    check("lock_not_early", early, 1'b0);
    step();
    check("lock_ready", ready, 1'b1);
    check("lock_sys_reset_n", sys_reset_n, 1'b1);

    // Table: rates, phase, mask and resync
    for (int i = 0; i < 38; i++) begin
      ce_mask = tbl[i].mask;
      resync  = tbl[i].rs;
      step();
      check($sformatf("vec%0d", i + 1), ce_out, tbl[i].exp);
    end
    resync  = 1'b0;
    ce_mask = 5'h1f;

    cnt0 = 0;
    cnt3 = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      cnt0 += int'(ce_out[0]);
      cnt3 += int'(ce_out[3]);
    end
    check("ch0_pulses_100", cnt0, 25);
    check("ch3_inc0_pulses", cnt3, 0);

    // New inc applies from the edge after the write
    resync = 1'b1;
    step();
    resync = 1'b0;
    check("resync_ce_zero", ce_out, '0);
    step_n(2);
    write_cfg(3'd0, 8'd128, 8'd0);
    check("inc_chg_e3", ce_out[0], 1'b0);
    step();
    check("inc_chg_e4", ce_out[0], 1'b1);
    step();
    check("inc_chg_e5", ce_out[0], 1'b0);
    step();
    check("inc_chg_e6", ce_out[0], 1'b1);

    // Out-of-range channel write must leave every channel untouched
    write_cfg(3'd5, 8'hff, 8'h40);
    resync = 1'b1;
    step();
    resync = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("oor_e%0d", k + 1), ce_out, exp_oor[k]);
    end

    // Resync together with a phase write loads the old phase
    resync = 1'b1;
    write_cfg(3'd0, 8'd64, 8'h80);
    resync = 1'b0;
    check("sim_resync_ce_zero", ce_out, '0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("sim_old_phase_e%0d", k), ce_out[0], (k == 4));
    end
    resync = 1'b1;
    step();
    resync = 1'b0;
    step();
    check("new_phase_e1", ce_out[0], 1'b0);
    step();
    check("new_phase_e2", ce_out[0], 1'b1);

    // Lock loss in RUN: seen after two synchroniser stages
    pll_locked = 1'b0;
    step();
    check("loss_e1_ready", ready, 1'b1);
    step();
    check("loss_e2_ready", ready, 1'b1);
    step();
    check("loss_e3_ready", ready, 1'b0);
    check("loss_e3_sys_reset_n", sys_reset_n, 1'b0);
    check("loss_e3_ce_out", ce_out, '0);

    // Re-lock with a 3-cycle drop during STABILISE restarts the count
    pll_locked = 1'b1;
    step_n(5);
    pll_locked = 1'b0;
    step_n(3);
    pll_locked = 1'b1;
    early = 1'b0;
    for (int k = 0; k < LD + 2; k++) begin
      step();
      if (ready || (ce_out != '0)) early = 1'b1;
    end
    check("relock_not_early", early, 1'b0);
    step();
    check("relock_ready", ready, 1'b1);
    step();
    check("relock_phase_e1", ce_out[0], 1'b0);
    step();
    check("relock_phase_e2", ce_out[0], 1'b1);

    // Asynchronous reset mid-RUN
    for (int k = 0; k < 8; k++) begin
      if (ce_out != '0) break;
      step();
    end
    check("pre_reset_pulse_seen", (ce_out != '0), 1'b1);
    reset = 1'b0;
    #1;
    check("async_rst_ready", ready, 1'b0);
    check("async_rst_sys_reset_n", sys_reset_n, 1'b0);
    check("async_rst_ce_out", ce_out, '0);
    #1;
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < LD + 9; k++) begin
      step();
      if (ce_out != '0) pulses++;
    end
    check("post_rst_ready", ready, 1'b1);
    check("post_rst_inc_default_pulses", pulses, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
